// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mul_pkg;

    localparam int unsigned MUL_N_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/multiplier_seq_if.sv
// Request/result bundle between a requester (master) and multiplier_seq (slave).
interface multiplier_seq_if
    import mul_pkg::*;
#(
    parameter int unsigned N = MUL_N_DEFAULT
);

    logic           req;
    logic [N-1:0]   Multiplicand;
    logic [N-1:0]   Multiplier;
    logic [2*N-1:0] P;
    logic           ready;
    logic           busy;

    modport master (
        output req, Multiplicand, Multiplier,
        input  P, ready, busy
    );

    modport slave (
        input  req, Multiplicand, Multiplier,
        output P, ready, busy
    );

endinterface

// File: rtl/mul_step.sv
// One shift-and-add iteration: consumes the multiplier LSB and shifts both operands.
module mul_step
    import mul_pkg::*;
#(
    parameter int unsigned N = MUL_N_DEFAULT
) (
    input  logic [2*N-1:0] acc,
    input  logic [2*N-1:0] mcand,
    input  logic [N-1:0]   mplier,
    output logic [2*N-1:0] acc_nxt_c,
    output logic [2*N-1:0] mcand_nxt_c,
    output logic [N-1:0]   mplier_nxt_c,
    output logic           zero_c
);

    always_comb begin
        acc_nxt_c    = mplier[0] ? (acc + mcand) : acc;
        mcand_nxt_c  = mcand << 1;
        mplier_nxt_c = mplier >> 1;
        zero_c       = (mplier_nxt_c == '0);
    end

endmodule

// File: rtl/multiplier_seq.sv
// Sequential N-bit unsigned multiplier, one multiplier bit per cycle.
// Define MUL_EARLY_TERM_EN to finish as soon as no multiplier bits remain set.
module multiplier_seq
    import mul_pkg::*;
#(
    parameter int unsigned N = MUL_N_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    multiplier_seq_if.slave bus
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned CW = $clog2(N + 1);

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    mul_state_t     state, state_nxt;
    logic [W-1:0]   acc, acc_nxt;
    logic [W-1:0]   mcand, mcand_nxt;
    logic [N-1:0]   mplier, mplier_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [W-1:0]   p_nxt;
    logic           ready_nxt;
    logic           busy_nxt;
    logic           last_c;

    logic [W-1:0]   step_acc;
    logic [W-1:0]   step_mcand;
    logic [N-1:0]   step_mplier;
    logic           step_zero;

    mul_step #(.N(N)) u_step (
        .acc          (acc),
        .mcand        (mcand),
        .mplier       (mplier),
        .acc_nxt_c    (step_acc),
        .mcand_nxt_c  (step_mcand),
        .mplier_nxt_c (step_mplier),
        .zero_c       (step_zero)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            bus.P     <= '0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            cnt       <= cnt_nxt;
            bus.P     <= p_nxt;
            bus.ready <= ready_nxt;
            bus.busy  <= busy_nxt;
        end
    end

    // Final step: all N bits consumed, or (early-term build) nothing left to add
    always_comb begin
        last_c = (cnt == CW'(N - 1)) || (EARLY_TERM && step_zero);
    end

    // Next-state and register updates
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        p_nxt      = bus.P;
        ready_nxt  = 1'b0;
        busy_nxt   = bus.busy;

        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    acc_nxt    = '0;
                    mcand_nxt  = {{N{1'b0}}, bus.Multiplicand};
                    mplier_nxt = bus.Multiplier;
                    cnt_nxt    = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                acc_nxt    = step_acc;
                mcand_nxt  = step_mcand;
                mplier_nxt = step_mplier;
                cnt_nxt    = cnt + CW'(1);
                if (last_c) begin
                    p_nxt     = step_acc;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
